pc_predict_unit: RTL and testbench
==================================

// Module: pc_predict_unit
// PURPOSE
//  Parametrised next-PC unit with fetch-time prediction. Holds the fetch PC and predicts
//  redirects through a direct-mapped BTB with 2-bit counters. Carries prediction tags down a
//  DEPTH-stage shadow pipe and resolves each branch against the flags at the resolve stage.
//  Raises flush/redirect on a misprediction.
// PARAMETERS
//  PC_W        16  PC / target width (bits); PC LSB always 0
//  IMM_W       9   signed branch immediate width (halfword offset)
//  DEPTH       3   pipe stages from fetch to resolve (>=1)
//  BTB_ENTRIES 16  BTB entries, power of 2, >=2; IDX_W=log2(BTB_ENTRIES)
//  RESET_PC    0   fetch PC after reset
// PORTS
//  clk          in  1      clock
//  rst          in  1      synchronous active-high reset
//  stall        in  1      hold PC, shadow pipe and resolve (no BTB update)
//  pc           out PC_W   current fetch PC (registered)
//  res_valid    in  1      resolve-stage slot holds a real instruction
//  res_is_br    in  1      instruction is a branch (B or BR)
//  res_is_reg   in  1      1=BR (register target), 0=B (PC-relative)
//  res_cond     in  3      condition code
//  res_imm      in  IMM_W  signed offset, halfwords
//  res_reg_tgt  in  PC_W   register target for BR
//  res_flags    in  3      {Z,V,N} at resolve
//  res_pc_plus2 out PC_W   PC+2 of resolve-stage instruction (PCS link value)
//  br_taken     out 1      resolved branch taken (comb, qualified by res_valid&res_is_br&!stall)
//  flush        out 1      mispredict this cycle; squash all younger stages (comb)
// BEHAVIOUR
//  Reset: pc=RESET_PC; all BTB valid=0 and counters=2'b01; shadow pipe all invalid;
//   flush=0, br_taken=0.
//  BTB lookup on pc:
//   - idx=pc[IDX_W:1], tag=pc[PC_W-1:IDX_W+1].
//   - pred_taken = valid & tag match & ctr>=2; pred_next = pred_taken ? stored target : pc+2.
//  Shadow pipe: DEPTH entries {valid,pc,pred_next}.
//   - On !stall & !flush: shift one stage; push {1,pc,pred_next}; pc<=pred_next.
//   - Stall: everything holds. BTB read is combinational; the write lands at the clock edge.
//  Resolve (head entry hd), evaluated only when !stall & res_valid & hd.valid:
//   - cond (Z,V,N): 000 Z=0 | 001 Z=1 | 010 Z=0&N=0 | 011 N=1 | 100 Z=1|(Z=0&N=0) | 101 Z=1|N=1
//     | 110 V=1 | 111 always.
//   - taken = res_is_br & cond_true.
//   - target = res_is_reg ? res_reg_tgt : hd.pc+2+(sext(res_imm)<<1); arithmetic mod 2^PC_W.
//   - actual_next = taken ? target : hd.pc+2; res_pc_plus2 = hd.pc+2.
//   - flush = (actual_next != hd.pred_next).
//   - On flush: next edge pc<=actual_next, all pipe entries invalid, no push that cycle.
//  BTB update at resolve (same qualification):
//   - Branch, index hit: ctr sat inc if taken else sat dec (00/11 saturate); target<=target
//     if taken.
//   - Branch, miss & taken: allocate {valid,tag,target,ctr=2'b10}.
//   - Branch, miss & not taken: no write.
//   - Non-branch, hit: clear valid (alias). Its flush is covered by the mispredict rule.
//  Bubble (res_valid=0 or hd invalid): no flush, no update, br_taken=0.
//  Simultaneous lookup/update on the same idx: lookup sees pre-update contents.
//  Reset mid-operation overrides stall/flush; the state returns fully to reset values.
// TESTING
//  1 Reset, no branches, 10 cycles -> pc=0,2,..,0x14; flush never 1.
//  2 B cond=111 imm=+4 at PC 0x10 (cold BTB) -> flush=1 at resolve, next pc=0x1A,
//    BTB[8] ctr=10.
//  3 Same branch refetched -> predicted; pc 0x10 then 0x1A without bubble; resolve flush=0,
//    ctr=11.
//  4 cond=000 with Z=1 on trained entry -> flush, pc<=0x12, ctr 11->10.
//    Repeat -> 01, then no prediction.
//  5 BR res_reg_tgt=0x0400 with stall high for 3 cycles at resolve -> pc, pipe and BTB hold;
//    flush only after stall drops, pc<=0x0400.
//  6 imm=-256 at PC 0x0000 -> target wraps to 0xFE02.
//    rst asserted mid-redirect -> pc=RESET_PC, BTB invalid.

Source files
------------

// File: rtl/pc_predict_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_predict_unit
// Purpose  : Next-PC unit with a direct-mapped BTB predictor, a shadow pipe of
//            prediction tags, and branch resolution that raises a flush on mispredict.
// Revision : 1.0 - initial release
// ============================================================================
module pc_predict_unit #(
  parameter int              PC_W        = 16,
  parameter int              IMM_W       = 9,
  parameter int              DEPTH       = 3,
  parameter int              BTB_ENTRIES = 16,
  parameter logic [PC_W-1:0] RESET_PC    = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_i,
  output logic [PC_W-1:0]  pc_o,
  input  logic             res_valid_i,
  input  logic             res_is_br_i,
  input  logic             res_is_reg_i,
  input  logic [2:0]       res_cond_i,
  input  logic [IMM_W-1:0] res_imm_i,
  input  logic [PC_W-1:0]  res_reg_tgt_i,
  input  logic [2:0]       res_flags_i,
  output logic [PC_W-1:0]  res_pc_plus2_o,
  output logic             br_taken_o,
  output logic             flush_o
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 1;

  logic [PC_W-1:0]  pc_q, pc_d;

  logic [BTB_ENTRIES-1:0] btb_vld_q;
  logic [TAG_W-1:0]       btb_tag_q [BTB_ENTRIES];
  logic [PC_W-1:0]        btb_tgt_q [BTB_ENTRIES];
  logic [1:0]             btb_ctr_q [BTB_ENTRIES];

  logic            pv_q  [DEPTH];
  logic [PC_W-1:0] ppc_q [DEPTH];
  logic [PC_W-1:0] ppn_q [DEPTH];

  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic             pred_taken;
  logic [PC_W-1:0]  pred_next;

  logic             hd_vld;
  logic [PC_W-1:0]  hd_pc, hd_pn, hd_p2, imm_off, target, actual_next;
  logic             do_res, cond_true, taken;
  logic [IDX_W-1:0] r_idx;
  logic [TAG_W-1:0] r_tag;
  logic             r_hit;

  // Fetch-side lookup
  assign f_idx      = pc_q[IDX_W:1];
  assign f_tag      = pc_q[PC_W-1:IDX_W+1];
  assign pred_taken = btb_vld_q[f_idx] && (btb_tag_q[f_idx] == f_tag) && btb_ctr_q[f_idx][1];
  assign pred_next  = pred_taken ? btb_tgt_q[f_idx] : pc_q + PC_W'(2);

  assign hd_vld = pv_q[DEPTH-1];
  assign hd_pc  = ppc_q[DEPTH-1];
  assign hd_pn  = ppn_q[DEPTH-1];
  assign hd_p2  = hd_pc + PC_W'(2);
  assign do_res = !stall_i && res_valid_i && hd_vld;

  // Flags are {Z,V,N}
  always_comb begin
    cond_true = 1'b0;
    case (res_cond_i)
      3'b000: cond_true = !res_flags_i[2];
      3'b001: cond_true = res_flags_i[2];
      3'b010: cond_true = !res_flags_i[2] && !res_flags_i[0];
      3'b011: cond_true = res_flags_i[0];
      3'b100: cond_true = res_flags_i[2] || !res_flags_i[0];
      3'b101: cond_true = res_flags_i[2] || res_flags_i[0];
      3'b110: cond_true = res_flags_i[1];
      default: cond_true = 1'b1;
    endcase
  end

  assign imm_off     = PC_W'($signed(res_imm_i));
  assign taken       = res_is_br_i && cond_true;
  assign target      = res_is_reg_i ? res_reg_tgt_i : hd_p2 + (imm_off << 1);
  assign actual_next = taken ? target : hd_p2;

  assign flush_o        = do_res && (actual_next != hd_pn);
  assign br_taken_o     = do_res && taken;
  assign res_pc_plus2_o = hd_p2;
  assign pc_o           = pc_q;

  assign r_idx = hd_pc[IDX_W:1];
  assign r_tag = hd_pc[PC_W-1:IDX_W+1];
  assign r_hit = btb_vld_q[r_idx] && (btb_tag_q[r_idx] == r_tag);

  always_comb begin
    pc_d = pc_q;
    if (!stall_i) pc_d = flush_o ? actual_next : pred_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
      for (int i = 0; i < DEPTH; i++) begin
        pv_q[i]  <= 1'b0;
        ppc_q[i] <= '0;
        ppn_q[i] <= '0;
      end
      for (int e = 0; e < BTB_ENTRIES; e++) begin
        btb_vld_q[e] <= 1'b0;
        btb_tag_q[e] <= '0;
        btb_tgt_q[e] <= '0;
        btb_ctr_q[e] <= 2'b01;
      end
    end else begin
      pc_q <= pc_d;
      if (!stall_i) begin
        if (flush_o) begin
          for (int i = 0; i < DEPTH; i++) pv_q[i] <= 1'b0;
        end else begin
          for (int i = DEPTH - 1; i > 0; i--) begin
            pv_q[i]  <= pv_q[i-1];
            ppc_q[i] <= ppc_q[i-1];
            ppn_q[i] <= ppn_q[i-1];
          end
          pv_q[0]  <= 1'b1;
          ppc_q[0] <= pc_q;
          ppn_q[0] <= pred_next;
        end
      end
      // A non-branch that hits means the entry aliases it; drop the entry.
      if (do_res) begin
        if (res_is_br_i && r_hit) begin
          if (taken) begin
            btb_tgt_q[r_idx] <= target;
            if (btb_ctr_q[r_idx] != 2'b11) btb_ctr_q[r_idx] <= btb_ctr_q[r_idx] + 2'b01;
          end else if (btb_ctr_q[r_idx] != 2'b00) begin
            btb_ctr_q[r_idx] <= btb_ctr_q[r_idx] - 2'b01;
          end
        end else if (res_is_br_i && taken) begin
          btb_vld_q[r_idx] <= 1'b1;
          btb_tag_q[r_idx] <= r_tag;
          btb_tgt_q[r_idx] <= target;
          btb_ctr_q[r_idx] <= 2'b10;
        end else if (!res_is_br_i && r_hit) begin
          btb_vld_q[r_idx] <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_predict_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_predict_unit
// Purpose  : Directed stimulus with hand-computed expectations for pc_predict_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_predict_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_i = 1'b0;
  logic [15:0] pc_o;
  logic        res_valid_i = 1'b1;
  logic        res_is_br_i = 1'b0;
  logic        res_is_reg_i = 1'b0;
  logic [2:0]  res_cond_i = 3'd0;
  logic [8:0]  res_imm_i = 9'd0;
  logic [15:0] res_reg_tgt_i = 16'd0;
  logic [2:0]  res_flags_i = 3'd0;
  logic [15:0] res_pc_plus2_o;
  logic        br_taken_o;
  logic        flush_o;

  pc_predict_unit #(
    .PC_W(16), .IMM_W(9), .DEPTH(3), .BTB_ENTRIES(16), .RESET_PC(16'h0000)
  ) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .pc_o(pc_o),
    .res_valid_i(res_valid_i), .res_is_br_i(res_is_br_i), .res_is_reg_i(res_is_reg_i),
    .res_cond_i(res_cond_i), .res_imm_i(res_imm_i), .res_reg_tgt_i(res_reg_tgt_i),
    .res_flags_i(res_flags_i), .res_pc_plus2_o(res_pc_plus2_o),
    .br_taken_o(br_taken_o), .flush_o(flush_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ck;
    logic        ckp;
    logic [15:0] pc;
    logic        fl;
    logic        tk;
    logic [15:0] p2;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc_n  = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      if (e.ck) begin
        check("pc", pc_o, e.pc);
        check("flush", {15'd0, flush_o}, {15'd0, e.fl});
        check("br_taken", {15'd0, br_taken_o}, {15'd0, e.tk});
      end
      if (e.ckp) check("res_pc_plus2", res_pc_plus2_o, e.p2);
    end
  end

  task automatic cyc(input logic r, s, b, rg, input logic [2:0] cd, input logic [8:0] im,
                     input logic [15:0] tg, input logic [2:0] fl, input logic ck,
                     input logic [15:0] epc, input logic efl, etk, ckp, input logic [15:0] ep2);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; stall_i = s; res_is_br_i = b; res_is_reg_i = rg;
    res_cond_i = cd; res_imm_i = im; res_reg_tgt_i = tg; res_flags_i = fl;
    e.ck = ck; e.ckp = ckp; e.pc = epc; e.fl = efl; e.tk = etk; e.p2 = ep2;
    q.push_back(e);
    cyc_n++;
  endtask

  task automatic nb(input logic [15:0] epc);
    cyc(0, 0, 0, 0, 3'd0, 9'd0, 16'd0, 3'd0, 1, epc, 0, 0, 0, 16'd0);
  endtask

  task automatic bcy(input logic s, rg, input logic [2:0] cd, input logic [8:0] im,
                     input logic [15:0] tg, input logic [2:0] fl, input logic [15:0] epc,
                     input logic efl, etk, input logic [15:0] ep2);
    cyc(0, s, 1, rg, cd, im, tg, fl, 1, epc, efl, etk, 1, ep2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // Reset: first cycle is undefined, second shows the reset state
    cyc(1, 0, 0, 0, 3'd0, 9'd0, 16'd0, 3'd0, 0, 16'd0, 0, 0, 0, 16'd0);
    cyc(1, 0, 0, 0, 3'd0, 9'd0, 16'd0, 3'd0, 1, 16'h0000, 0, 0, 0, 16'd0);
    for (int c = 0; c <= 10; c++) nb(16'(2 * c));
    // Cold B always +4 at 0x10 resolves at pc 0x16
    bcy(0, 0, 3'b111, 9'd4, 16'd0, 3'b000, 16'h0016, 1, 1, 16'h0012);
    nb(16'h001A); nb(16'h001C); nb(16'h001E);
    // BR at 0x1A back to 0x10
    bcy(0, 1, 3'b111, 9'd0, 16'h0010, 3'b000, 16'h0020, 1, 1, 16'h001C);
    nb(16'h0010); nb(16'h001A); nb(16'h0010);
    // Trained branch resolves with no flush
    bcy(0, 0, 3'b111, 9'd4, 16'd0, 3'b000, 16'h001A, 0, 1, 16'h0012);
    bcy(0, 1, 3'b111, 9'd0, 16'h0010, 3'b000, 16'h0010, 0, 1, 16'h001C);
    // cond=000 with Z=1: not taken, mispredict
    bcy(0, 0, 3'b000, 9'd4, 16'd0, 3'b100, 16'h001A, 1, 0, 16'h0012);
    nb(16'h0012); nb(16'h0014); nb(16'h0016); nb(16'h0018);
    nb(16'h001A); nb(16'h0010); nb(16'h001A);
    bcy(0, 1, 3'b111, 9'd0, 16'h0010, 3'b000, 16'h0010, 0, 1, 16'h001C);
    bcy(0, 0, 3'b000, 9'd4, 16'd0, 3'b100, 16'h001A, 1, 0, 16'h0012);
    nb(16'h0012); nb(16'h0014); nb(16'h0016); nb(16'h0018);
    nb(16'h001A); nb(16'h0010);
    // Counter now weakly not-taken: 0x10 falls through to 0x12
    nb(16'h0012);
    bcy(0, 1, 3'b111, 9'd0, 16'h0010, 3'b000, 16'h0014, 0, 1, 16'h001C);
    bcy(0, 0, 3'b000, 9'd4, 16'd0, 3'b100, 16'h0016, 0, 0, 16'h0012);
    // BR to 0x0400 held by stall for three cycles
    for (int k = 0; k < 3; k++)
      bcy(1, 1, 3'b111, 9'd0, 16'h0400, 3'b000, 16'h0018, 0, 0, 16'h0014);
    bcy(0, 1, 3'b111, 9'd0, 16'h0400, 3'b000, 16'h0018, 1, 1, 16'h0014);
    nb(16'h0400); nb(16'h0402); nb(16'h0404);
    bcy(0, 1, 3'b111, 9'd0, 16'h0000, 3'b000, 16'h0406, 1, 1, 16'h0402);
    nb(16'h0000); nb(16'h0002); nb(16'h0004);
    // imm=-256 at 0x0000 wraps to 0xFE02
    bcy(0, 0, 3'b111, 9'h100, 16'd0, 3'b000, 16'h0006, 1, 1, 16'h0002);
    nb(16'hFE02); nb(16'hFE04); nb(16'hFE06);
    // Reset lands during a redirect
    cyc(1, 0, 1, 1, 3'b111, 9'd0, 16'h0100, 3'd0, 0, 16'd0, 0, 0, 0, 16'd0);
    // BTB must be empty again: 0x1A and 0x12 fall through sequentially
    for (int c = 0; c <= 14; c++) nb(16'(2 * c));
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
